// File: rtl/shared_mem_sched_if.sv
// rtl/shared_mem_sched_if.sv - request/grant bundle between processor requesters and the shared-memory scheduler
interface shared_mem_sched_if #(
  parameter int COUNT = 4,
  parameter int LEN_W = 4
);
  logic [COUNT-1:0] i_req;
  logic [COUNT-1:0] i_wr;
  logic [LEN_W-1:0] i_len [COUNT];
  logic [COUNT-1:0] o_grant;
  logic             o_grant_wr;
  logic             o_beat;
  logic [LEN_W-1:0] o_beat_idx;
  logic [COUNT-1:0] o_done;
  logic [COUNT-1:0] o_abort;
  logic             o_busy;

  modport master (
    output i_req, i_wr, i_len,
    input  o_grant, o_grant_wr, o_beat, o_beat_idx, o_done, o_abort, o_busy
  );

  modport slave (
    input  i_req, i_wr, i_len,
    output o_grant, o_grant_wr, o_beat, o_beat_idx, o_done, o_abort, o_busy
  );
endinterface

// File: rtl/shared_mem_sched.sv
// rtl/shared_mem_sched.sv - round-robin burst scheduler granting one requester at a time to shared memory
module shared_mem_sched #(
  parameter int COUNT = 4,
  parameter int LEN_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  shared_mem_sched_if.slave bus
);
  localparam int IDX_W = $clog2(COUNT);

  typedef enum logic [1:0] {IDLE, BURST, TURN} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] rr_ptr, owner, winner, cand;
  logic             found;
  logic [LEN_W-1:0] len_q, beat_cnt;
  logic [COUNT-1:0] grant_q, owner_onehot;
  logic             grant_wr_q, busy_q;
  logic             owner_req, last_beat;

  assign owner_req    = bus.i_req[owner];
  assign last_beat    = (beat_cnt == len_q);
  assign owner_onehot = COUNT'(1) << owner;

  // First requester found scanning upward from rr_ptr, wrapping naturally in IDX_W bits
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < COUNT; k++) begin
      cand = rr_ptr + IDX_W'(k);
      if (!found && bus.i_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    bus.o_beat  = 1'b0;
    bus.o_done  = '0;
    bus.o_abort = '0;
    case (state)
      IDLE: begin
        if (found) state_n = BURST;
      end
      BURST: begin
        if (owner_req) begin
          bus.o_beat = 1'b1;
          if (last_beat) begin
            bus.o_done = owner_onehot;
            state_n    = TURN;
          end
        end else begin
          bus.o_abort = owner_onehot;
          state_n     = TURN;
        end
      end
      TURN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rr_ptr     <= '0;
      owner      <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      grant_q    <= '0;
      grant_wr_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (found) begin
            owner      <= winner;
            grant_q    <= COUNT'(1) << winner;
            grant_wr_q <= bus.i_wr[winner];
            len_q      <= bus.i_len[winner];
            beat_cnt   <= '0;
          end
        end
        BURST: begin
          // Counter holds on the last beat so a full-length burst never wraps
          if (state_n == TURN) begin
            grant_q    <= '0;
            grant_wr_q <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        TURN: begin
          rr_ptr   <= owner + 1'b1;
          beat_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_grant    = grant_q;
  assign bus.o_grant_wr = grant_wr_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_beat_idx = beat_cnt;
endmodule

// File: doc/shared_mem_sched.md
SHARED_MEM_SCHED -- requirements
Module: shared_mem_sched

Interface
REQ-001 COUNT, 4, number of processor requesters; power of 2, >=2.
REQ-002 LEN_W, 4, width of per-requester burst-length field.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  reset; synchronous, active-low.
REQ-005 i_req  input  COUNT  per-requester shared-memory access request; level, held until done.
REQ-006 i_wr  input  COUNT  per-requester direction: 1=write, 0=read.
REQ-007 i_len  input  COUNT x LEN_W  per-requester burst length minus one (unpacked array).
REQ-008 o_grant  output  COUNT  one-hot grant to current owner; all-zero when no owner.
REQ-009 o_grant_wr  output  1  latched direction of current burst.
REQ-010 o_beat  output  1  high in each cycle a beat is issued to memory.
REQ-011 o_beat_idx  output  LEN_W  index of current beat within burst.
REQ-012 o_done  output  COUNT  one-cycle pulse to owner on last beat.
REQ-013 o_abort  output  COUNT  one-cycle pulse to owner when it drops i_req mid-burst.
REQ-014 o_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, BURST, TURN.
REQ-016 IDLE: if any i_req bit high, SHALL select winner by round-robin starting at rr_ptr (order rr_ptr, rr_ptr+1, ..., wrapping mod COUNT), then enter BURST next cycle; else stay IDLE.
REQ-017 On IDLE->BURST SHALL register o_grant=onehot(winner), o_grant_wr=i_wr[winner], len_q=i_len[winner], beat_cnt=0; request-to-grant latency 1 cycle.
REQ-018 BURST, owner i_req high: o_beat=1, o_beat_idx=beat_cnt; beat_cnt increments by 1 each such cycle.
REQ-019 BURST, beat_cnt==len_q with owner i_req high: o_done[owner]=1 same cycle as last beat; next state TURN.
REQ-020 BURST, owner i_req low: o_beat=0, o_abort[owner]=1 that cycle, no o_done; next state TURN.
REQ-021 TURN: one cycle, o_grant=0, o_beat=0; rr_ptr <= (owner+1) mod COUNT; next state IDLE.
REQ-022 rr_ptr SHALL change only in TURN (after completion or abort).
REQ-023 Owner changes to i_len/i_wr during BURST SHALL be ignored; only values latched at grant apply.
REQ-024 Non-owner i_req during BURST/TURN SHALL have no effect until next IDLE.
REQ-025 o_grant, o_grant_wr SHALL stay constant through entire BURST including last-beat cycle.
REQ-026 len_q=2^LEN_W-1 SHALL yield 2^LEN_W beats; beat_cnt SHALL not wrap before done.
REQ-027 o_grant, o_grant_wr, o_busy, o_beat_idx SHALL be registered; o_beat, o_done, o_abort decoded from state and owner i_req in same cycle.
REQ-028 Continuously requesting requester SHALL be granted within at most COUNT-1 other bursts.
REQ-029 Minimum burst period SHALL be len+1 beat cycles plus 2 overhead cycles (TURN, IDLE).

Reset
REQ-030 i_rstn low at a rising edge: state=IDLE, rr_ptr=0, beat_cnt=0, len_q=0, all outputs 0.
REQ-031 Reset mid-burst SHALL abandon burst silently: no o_done, no o_abort pulse.
REQ-032 First arbitration after reset release SHALL start priority at requester 0.

Verification
REQ-033 i_req=0001, i_len[0]=3, i_wr[0]=1 -> o_grant=0001, o_grant_wr=1 next cycle; o_beat 4 cycles idx 0..3; o_done=0001 at idx 3; then TURN, IDLE, o_busy low.
REQ-034 i_req=1111 held, all i_len=0 -> grant order 0,1,2,3,0; one beat each; 3-cycle period; o_done per grant.
REQ-035 i_req=0010, i_len[1]=7; drop i_req[1] after idx 2 -> following cycle o_beat=0, o_abort=0010, no o_done; next grant priority starts at requester 2.
REQ-036 Reset asserted at idx 4 of burst -> all outputs 0 next cycle, no o_done/o_abort; after release with i_req=1001 -> o_grant=0001.
REQ-037 i_len[2]=15 -> 16 beats idx 0..15, o_done=0100 at idx 15; owner changes i_len[2] to 1 mid-burst -> still 16 beats.
